// File: rtl/regfiletmp_ctrl.sv
// ---------------------------------------------------------------------------
// regfiletmp_ctrl
// Sequencing and arbitration controller for the 32-entry temporary register
// file (regfiletmp). Entries are allocated in circular order at dispatch,
// marked complete by the completion bus, and retired in order from the head.
// The register file's single write port is shared between dispatch
// (New_entry) and completion (Update_entry). Completion normally wins the
// port; after STARVE_MAX consecutive losses, dispatch is forced to win.
//
// Optional feature macro: RFTMP_FLUSH_EN
//   When defined, a 'flush' input exists. It clears all tracking state at the
//   next edge, suppresses every grant that cycle, and zeroes the rf_* strobes
//   on the following cycle.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   disp_valid/data      dispatch request and new entry contents
//   disp_ready/tag       dispatch accepted this cycle, allocated entry (tail)
//   cmp_valid/tag/data   completion request, target entry, updated contents
//   cmp_ready            completion consumed this cycle
//   cmp_stale            registered pulse: completion hit an unallocated entry
//   commit_valid/tag     head entry allocated and completed, head pointer
//   commit_ready         commit stage retires the head
//   rf_data_in/waddr     register-file write data and address (registered)
//   rf_new_entry         register-file New_entry strobe (registered)
//   rf_update_entry      register-file Update_entry strobe (registered)
//   count                number of allocated entries, 0..DEPTH
//   flush                synchronous state clear (RFTMP_FLUSH_EN only)
// ---------------------------------------------------------------------------
module regfiletmp_ctrl #(
  parameter int DATA_W     = 73,
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [DATA_W-1:0] disp_data,
  output logic              disp_ready,
  output logic [AW-1:0]     disp_tag,
  input  logic              cmp_valid,
  input  logic [AW-1:0]     cmp_tag,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              cmp_ready,
  output logic              cmp_stale,
  output logic              commit_valid,
  output logic [AW-1:0]     commit_tag,
  input  logic              commit_ready,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [AW-1:0]     rf_waddr,
  output logic              rf_new_entry,
  output logic              rf_update_entry,
  output logic [AW:0]       count
`ifdef RFTMP_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [DEPTH-1:0] alloc_r;
  logic [DEPTH-1:0] done_r;
  logic [1:0]       starve_cnt_r;

  logic             flush_s;
  logic             full_s;
  logic             disp_elig_s;
  logic             cmp_req_s;
  logic             disp_win_s;
  logic             cmp_win_s;
  logic             cmp_hit_s;
  logic             commit_fire_s;
  logic [AW:0]      count_nxt_s;
  logic [1:0]       starve_nxt_s;
  logic [DEPTH-1:0] alloc_nxt_s;
  logic [DEPTH-1:0] done_nxt_s;

`ifdef RFTMP_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Arbitration for the single write port and commit handshake.
  // Full is taken from the registered count, so a same-cycle commit never
  // frees a slot for dispatch. Requests are masked while reset or flush is
  // high so nothing is granted in those cycles.
  always_comb begin
    full_s        = (count == (AW+1)'(DEPTH));
    disp_elig_s   = disp_valid && !full_s && !reset && !flush_s;
    cmp_req_s     = cmp_valid && !reset && !flush_s;
    disp_win_s    = disp_elig_s &&
                    (!cmp_req_s || (starve_cnt_r == 2'(STARVE_MAX)));
    cmp_win_s     = cmp_req_s && !disp_win_s;
    cmp_hit_s     = cmp_win_s && alloc_r[cmp_tag];
    commit_valid  = alloc_r[head_r] && done_r[head_r] && !reset && !flush_s;
    commit_fire_s = commit_valid && commit_ready;
    disp_ready    = disp_win_s;
    cmp_ready     = cmp_win_s;
    disp_tag      = tail_r;
    commit_tag    = head_r;
    count_nxt_s   = count + {{AW{1'b0}}, disp_win_s}
                          - {{AW{1'b0}}, commit_fire_s};
    // Losing while eligible builds up starvation; anything else clears it.
    starve_nxt_s  = (disp_elig_s && !disp_win_s) ? (starve_cnt_r + 2'd1) : 2'd0;
  end

  // Per-entry allocation/completion next state. A retiring head clears
  // both bits and takes priority; a completion can never coincide with a
  // dispatch because only one of them is granted per cycle.
  always_comb begin
    alloc_nxt_s = alloc_r;
    done_nxt_s  = done_r;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_nxt_s[i] = (commit_fire_s && (head_r == AW'(i))) ? 1'b0 :
                       ((disp_win_s && (tail_r == AW'(i))) ? 1'b1 : alloc_r[i]);
      done_nxt_s[i]  = (commit_fire_s && (head_r == AW'(i))) ? 1'b0 :
                       ((disp_win_s && (tail_r == AW'(i))) ? 1'b0 :
                        ((cmp_hit_s && (cmp_tag == AW'(i))) ? 1'b1 : done_r[i]));
    end
  end

  // Tracking state: pointers, occupancy, per-entry bits and starvation count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r       <= {AW{1'b0}};
      tail_r       <= {AW{1'b0}};
      count        <= {(AW+1){1'b0}};
      alloc_r      <= {DEPTH{1'b0}};
      done_r       <= {DEPTH{1'b0}};
      starve_cnt_r <= 2'd0;
    end else if (flush_s) begin
      head_r       <= {AW{1'b0}};
      tail_r       <= {AW{1'b0}};
      count        <= {(AW+1){1'b0}};
      alloc_r      <= {DEPTH{1'b0}};
      done_r       <= {DEPTH{1'b0}};
      starve_cnt_r <= 2'd0;
    end else begin
      head_r       <= commit_fire_s ? (head_r + AW'(1)) : head_r;
      tail_r       <= disp_win_s ? (tail_r + AW'(1)) : tail_r;
      count        <= count_nxt_s;
      alloc_r      <= alloc_nxt_s;
      done_r       <= done_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Registered write port toward regfiletmp plus the stale-completion pulse.
  // A stale completion is consumed but produces no write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_new_entry    <= 1'b0;
      rf_update_entry <= 1'b0;
      rf_waddr        <= {AW{1'b0}};
      rf_data_in      <= {DATA_W{1'b0}};
      cmp_stale       <= 1'b0;
    end else begin
      cmp_stale <= cmp_win_s && !alloc_r[cmp_tag];
      if (disp_win_s) begin
        rf_new_entry    <= 1'b1;
        rf_update_entry <= 1'b0;
        rf_waddr        <= tail_r;
        rf_data_in      <= disp_data;
      end else if (cmp_hit_s) begin
        rf_new_entry    <= 1'b0;
        rf_update_entry <= 1'b1;
        rf_waddr        <= cmp_tag;
        rf_data_in      <= cmp_data;
      end else begin
        rf_new_entry    <= 1'b0;
        rf_update_entry <= 1'b0;
        rf_waddr        <= rf_waddr;
        rf_data_in      <= rf_data_in;
      end
    end
  end

endmodule

// File: doc/regfiletmp_ctrl.md
Name: regfiletmp_ctrl

Overview:
Sequencing and arbitration controller for the 32-entry temporary register file (regfiletmp).
- Allocates entries in circular order for dispatched instructions.
- Shares the register file's single write port between dispatch (New_entry) and completion (Update_entry) requesters.
- Tracks per-entry completion and presents in-order commit of the oldest entry.
- Sits between the dispatch stage, the completion bus and the commit stage.

Parameters:
DATA_W, 73, entry width; layout rd_reg[72:37], PC[36:5], Inst_type[4:3], spec_data[2], spec_valid[1], valid[0]
DEPTH, 32, number of entries; power of two
AW, 5, entry address width, log2(DEPTH)
STARVE_MAX, 3, consecutive dispatch losses before dispatch is forced to win

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
disp_valid  in  1  dispatch request
disp_data  in  DATA_W  new entry contents
disp_ready  out  1  dispatch accepted this cycle
disp_tag  out  AW  entry allocated on accept (= tail)
cmp_valid  in  1  completion request
cmp_tag  in  AW  entry to update
cmp_data  in  DATA_W  updated entry contents
cmp_ready  out  1  completion consumed this cycle
cmp_stale  out  1  registered pulse: completion targeted an unallocated entry
commit_valid  out  1  head entry allocated and completed
commit_tag  out  AW  head pointer
commit_ready  in  1  commit stage retires the head
rf_data_in  out  DATA_W  to regfiletmp Data_In
rf_waddr  out  AW  to regfiletmp Waddr
rf_new_entry  out  1  to regfiletmp New_entry
rf_update_entry  out  1  to regfiletmp Update_entry
count  out  AW+1  allocated entries, 0..DEPTH
flush  in  1  present only with RFTMP_FLUSH_EN

Behaviour:
- State:
  - head, tail: AW bits, wrap modulo DEPTH.
  - count: AW+1 bits.
  - alloc[DEPTH] and done[DEPTH] bit vectors.
  - starve_cnt: 2 bits.
- Reset: all state and all registered outputs are 0. While reset is high, disp_ready, cmp_ready and commit_valid are 0.
- full = (count == DEPTH). empty = (count == 0). Both are computed from registered count. A commit in the same cycle does not unblock dispatch when full.
- Dispatch eligibility: disp_eligible = disp_valid && !full.
- Arbitration: one write per cycle.
  - Completion beats an eligible dispatch unless starve_cnt == STARVE_MAX, in which case dispatch wins.
  - starve_cnt increments when dispatch is eligible but loses.
  - starve_cnt clears when dispatch wins or is not eligible.
- disp_ready and cmp_ready are combinational from the arbitration result. A request granted is consumed that cycle.
- Dispatch accept:
  - tail increments; alloc[tail] is set and done[tail] is cleared.
  - Next cycle: rf_new_entry=1, rf_waddr=old tail, rf_data_in=disp_data.
- Completion accept with alloc[cmp_tag]=1:
  - done[cmp_tag] is set.
  - Next cycle: rf_update_entry=1, rf_waddr=cmp_tag, rf_data_in=cmp_data.
- Completion accept with alloc[cmp_tag]=0:
  - Consumed (cmp_ready=1), no register-file write, no state change.
  - cmp_stale=1 next cycle for one cycle.
- Write-port outputs: rf_new_entry and rf_update_entry are registered and never both 1. Write-port latency is 1 cycle; with no grant, both are 0 next cycle.
- Commit: commit_valid = alloc[head] && done[head]. A commit fires on commit_valid && commit_ready; head increments and alloc[head] and done[head] are cleared.
- Simultaneous events:
  - Dispatch and commit in the same cycle: count unchanged.
  - A completion to head in the same cycle: commit_valid is not yet set; it rises the next cycle.
- Wrap-around: tail and head roll from DEPTH-1 to 0 with no gap. Only count distinguishes full from empty when head == tail.
- Reset mid-operation: all allocations are discarded, and any pending rf_* pulse is cancelled immediately (asynchronous clear).

Optional Feature:
RFTMP_FLUSH_EN:
- Defined: flush port exists. flush=1 clears alloc, done, head, tail, count and starve_cnt at the next edge, suppresses all grants that cycle, and drives rf_* to 0 next cycle.
- Undefined: no flush port; only reset clears state.

Test Plan:
- Reset, then 32 dispatches with disp_data={i,...} -> disp_tag 0..31, rf_new_entry pulses with rf_waddr=i one cycle later, count=32. Then a 33rd dispatch -> disp_ready=0.
- Same cycle, cmp_valid (tag 3) and disp_valid (not full) held for 8 cycles -> completion wins 3 cycles, dispatch wins the 4th, and the pattern repeats; rf_new_entry and rf_update_entry are never both high.
- Allocate 0..3, complete tag 3 then tag 0, commit_ready=1 -> commit_tag 0 retires first, then commit_valid=0 until tags 1 and 2 complete; retire order 0,1,2,3.
- Complete tag 10 while unallocated -> cmp_ready=1, no rf_update_entry, cmp_stale=1 for one cycle.
- Fill 32, commit 5, dispatch 5 -> tail wraps 31->0..4, count=32, head=5.
- Assert reset while rf_update_entry=1 -> all outputs 0 immediately, count=0. With RFTMP_FLUSH_EN, flush=1 mid-stream -> count=0 next cycle and the next disp_tag is 0.
